// File: rtl/scancode_history_pkg.sv
//==============================================================================
// Module  : kbd_disp_pkg
// Purpose : Shared display constants and the hex-to-seven-segment decode used
//           by the keyboard front-end display blocks.
// Ports   : none (package)
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

package kbd_disp_pkg;

  // All segments off on an active-low display
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low segment pattern, bit order {g,f,e,d,c,b,a}
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/scancode_history_if.sv
//==============================================================================
// Module  : scancode_history_if
// Purpose : Scancode capture bundle from the receiver to the history buffer.
// Signals : code       - scancode, valid with new_code
//           make_break - flag stored alongside the code
//           new_code   - one-cycle capture strobe
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

interface scancode_history_if #(
  parameter int CODE_W = 8
);
  logic [CODE_W-1:0] code;
  logic              make_break;
  logic              new_code;

  modport master (output code, output make_break, output new_code);
  modport slave  (input  code, input  make_break, input  new_code);
endinterface

`default_nettype wire

// File: rtl/hist_ring.sv
//==============================================================================
// Module  : hist_ring
// Purpose : DEPTH-entry ring of {flag, code} with write pointer and saturating
//           valid count, plus NRD age-indexed read ports (age 0 = newest).
// Ports   : clk, rst_n            - clock, async active-low reset
//           wr_en/wr_flag/wr_code - write port
//           clr                   - empty the ring (priority over wr_en)
//           rd_age[]              - per-port age to read
//           rd_valid/flag/code[]  - per-port read result
//           count, count_nxt      - current and next valid-entry count
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module hist_ring #(
  parameter int CODE_W = 8,
  parameter int DEPTH  = 16,
  parameter int NRD    = 10,
  parameter int CW     = 5,
  parameter int AGE_W  = 6
) (
  input  wire logic                             clk,
  input  wire logic                             rst_n,
  input  wire logic                             wr_en,
  input  wire logic                             clr,
  input  wire logic                             wr_flag,
  input  wire logic [CODE_W-1:0]                wr_code,
  input  wire logic [NRD-1:0][AGE_W-1:0]        rd_age,
  output logic      [NRD-1:0]                   rd_valid,
  output logic      [NRD-1:0]                   rd_flag,
  output logic      [NRD-1:0][CODE_W-1:0]       rd_code,
  output logic      [CW-1:0]                    count,
  output logic      [CW-1:0]                    count_nxt
);

  localparam int AW = $clog2(DEPTH);

  // Storage is intentionally not reset; count masks stale entries
  logic [CODE_W:0] mem_q [DEPTH];
  logic [AW-1:0]   wptr_q, wptr_d;
  logic [CW-1:0]   count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    count_d = count_q;
    if (clr) begin
      wptr_d  = '0;
      count_d = '0;
    end else if (wr_en) begin
      wptr_d = wptr_q + AW'(1);
      if (count_q != CW'(DEPTH)) count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem_q[wptr_q] <= {wr_flag, wr_code};
  end

  generate
    for (genvar r = 0; r < NRD; r++) begin : g_rd
      logic [AW-1:0]   idx;
      logic [CODE_W:0] ent;
      // Modulo-DEPTH wrap falls out of the AW-bit truncation
      assign idx         = wptr_q - AW'(1) - rd_age[r][AW-1:0];
      assign ent         = mem_q[idx];
      assign rd_valid[r] = rd_age[r] < AGE_W'(count_q);
      assign rd_flag[r]  = ent[CODE_W];
      assign rd_code[r]  = ent[CODE_W-1:0];
    end
  endgenerate

  assign count     = count_q;
  assign count_nxt = count_d;

endmodule

`default_nettype wire

// File: rtl/scancode_history.sv
//==============================================================================
// Module  : scancode_history
// Purpose : Scancode history buffer with a scrollable seven-segment window,
//           per-entry make/break LEDs, freeze, clear and lost-code flag.
// Ports   : clk, rst_n           - clock, async active-low reset
//           kbd (slave)          - code / make_break / new_code capture
//           scroll_up/scroll_dn  - view older / newer entries (pulses)
//           freeze, clear        - drop incoming codes / empty history
//           hex, led             - active-low digits, make/break flags
//           count, at_live, lost - status
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module scancode_history
  import kbd_disp_pkg::*;
#(
  parameter  int CODE_W = 8,
  parameter  int DEPTH  = 16,
  parameter  int NDIG   = 6,
  parameter  int NLED   = 10,
  localparam int WIN    = NDIG * 4 / CODE_W,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  scancode_history_if.slave    kbd,
  input  wire logic            scroll_up,
  input  wire logic            scroll_dn,
  input  wire logic            freeze,
  input  wire logic            clear,
  output logic [7*NDIG-1:0]    hex,
  output logic [NLED-1:0]      led,
  output logic [CW-1:0]        count,
  output logic                 at_live,
  output logic                 lost
);

  localparam int DPS   = CODE_W / 4;              // digits per entry
  localparam int NRD   = (WIN > NLED) ? WIN : NLED;
  localparam int AGE_W = CW + 1;

  logic                        wr_en;
  logic [CW-1:0]               count_nxt;
  logic [CW-1:0]               maxofs;
  logic [CW-1:0]               ofs_q, ofs_d;
  logic                        lost_q, lost_d;
  logic [NRD-1:0][AGE_W-1:0]   rd_age;
  logic [NRD-1:0]              rd_valid, rd_flag;
  logic [NRD-1:0][CODE_W-1:0]  rd_code;
  logic                        unused_rd;

  assign wr_en = kbd.new_code & ~freeze & ~clear;

  hist_ring #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH),
    .NRD    (NRD),
    .CW     (CW),
    .AGE_W  (AGE_W)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .clr       (clear),
    .wr_flag   (kbd.make_break),
    .wr_code   (kbd.code),
    .rd_age    (rd_age),
    .rd_valid  (rd_valid),
    .rd_flag   (rd_flag),
    .rd_code   (rd_code),
    .count     (count),
    .count_nxt (count_nxt)
  );

  // Scroll limit uses the post-write count so a write and scroll in one cycle
  // see the grown history
  assign maxofs = (count_nxt > CW'(WIN)) ? count_nxt - CW'(WIN) : '0;

  always_comb begin
    ofs_d = ofs_q;
    if (clear) begin
      ofs_d = '0;
    end else begin
      // Off-live view tracks its entries as new codes push them older
      if (wr_en && (ofs_q != '0))
        ofs_d = (ofs_q < maxofs) ? ofs_q + CW'(1) : maxofs;
      if (scroll_up && !scroll_dn && (ofs_d < maxofs))
        ofs_d = ofs_d + CW'(1);
      else if (scroll_dn && !scroll_up && (ofs_d != '0))
        ofs_d = ofs_d - CW'(1);
    end
  end

  always_comb begin
    lost_d = lost_q;
    if (clear)                      lost_d = 1'b0;
    else if (kbd.new_code & freeze) lost_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ofs_q  <= '0;
      lost_q <= 1'b0;
    end else begin
      ofs_q  <= ofs_d;
      lost_q <= lost_d;
    end
  end

  generate
    for (genvar r = 0; r < NRD; r++) begin : g_age
      assign rd_age[r] = AGE_W'(ofs_q) + AGE_W'(r);
    end

    for (genvar j = 0; j < WIN; j++) begin : g_slot
      for (genvar k = 0; k < DPS; k++) begin : g_dig
        assign hex[7*(j*DPS+k) +: 7] = rd_valid[j] ? hex_to_seg(rd_code[j][4*k +: 4])
                                                   : SEG_BLANK;
      end
    end

    for (genvar i = 0; i < NLED; i++) begin : g_led
      assign led[i] = rd_valid[i] & rd_flag[i];
    end
  endgenerate

  // Read ports beyond the window / LED range carry data nobody displays
  assign unused_rd = ^{rd_code, rd_flag};

  assign at_live = (ofs_q == '0);
  assign lost    = lost_q;

endmodule

`default_nettype wire

// File: tb/tb_scancode_history.sv
//==============================================================================
// Module  : tb_scancode_history
// Purpose : Self-checking bench for scancode_history (default parameters).
//           A queue-based reference history predicts every output; predictions
//           are queued at drive time and compared after the clock edge.
// Rev     : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_scancode_history;

  localparam int CODE_W = 8;
  localparam int DEPTH  = 16;
  localparam int NDIG   = 6;
  localparam int NLED   = 10;
  localparam int WIN    = 3;
  localparam int CW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              scroll_up = 1'b0;
  logic              scroll_dn = 1'b0;
  logic              freeze = 1'b0;
  logic              clear = 1'b0;
  logic [7*NDIG-1:0] hex;
  logic [NLED-1:0]   led;
  logic [CW-1:0]     count;
  logic              at_live;
  logic              lost;

  scancode_history_if #(.CODE_W(CODE_W)) kbd_if ();

  scancode_history #(
    .CODE_W (CODE_W),
    .DEPTH  (DEPTH),
    .NDIG   (NDIG),
    .NLED   (NLED)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .kbd       (kbd_if),
    .scroll_up (scroll_up),
    .scroll_dn (scroll_dn),
    .freeze    (freeze),
    .clear     (clear),
    .hex       (hex),
    .led       (led),
    .count     (count),
    .at_live   (at_live),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7*NDIG-1:0] hex;
    logic [NLED-1:0]   led;
    logic [CW-1:0]     cnt;
    logic              live;
    logic              lost;
  } exp_t;

  exp_t       sb[$];
  logic [8:0] hist[$];   // reference history, index = age
  int         m_ofs;
  bit         m_lost;
  int         checks;
  int         failures;

  localparam logic [7*NDIG-1:0] ALL_BLANK = {NDIG{7'h7F}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
      4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
      4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
      4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
    endcase
  endfunction

  // Expected digits reading left to right: e2 e1 e0
  function automatic logic [7*NDIG-1:0] hex3(input logic [7:0] e2, input logic [7:0] e1,
                                             input logic [7:0] e0);
    return {seg7(e2[7:4]), seg7(e2[3:0]), seg7(e1[7:4]), seg7(e1[3:0]),
            seg7(e0[7:4]), seg7(e0[3:0])};
  endfunction

  function automatic int maxofs();
    return (hist.size() > WIN) ? hist.size() - WIN : 0;
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.hex = ALL_BLANK;
    e.led = '0;
    for (int j = 0; j < WIN; j++) begin
      int a = m_ofs + j;
      if (a < hist.size()) begin
        e.hex[14*j     +: 7] = seg7(hist[a][3:0]);
        e.hex[14*j + 7 +: 7] = seg7(hist[a][7:4]);
      end
    end
    for (int i = 0; i < NLED; i++) begin
      int a = m_ofs + i;
      if (a < hist.size()) e.led[i] = hist[a][8];
    end
    e.cnt  = CW'(hist.size());
    e.live = (m_ofs == 0);
    e.lost = m_lost;
    return e;
  endfunction

  task automatic step(input bit nc, input logic [7:0] c, input bit mb, input bit up,
                      input bit dn, input bit frz, input bit clr);
    exp_t e;
    @(negedge clk);
    kbd_if.new_code   = nc;
    kbd_if.code       = c;
    kbd_if.make_break = mb;
    scroll_up = up;
    scroll_dn = dn;
    freeze    = frz;
    clear     = clr;
    if (clr) begin
      hist.delete();
      m_ofs  = 0;
      m_lost = 0;
    end else begin
      if (nc && frz) m_lost = 1;
      if (nc && !frz) begin
        hist.push_front({mb, c});
        if (hist.size() > DEPTH) void'(hist.pop_back());
        if (m_ofs != 0) m_ofs = (m_ofs + 1 < maxofs()) ? m_ofs + 1 : maxofs();
      end
      if (up && !dn && m_ofs < maxofs()) m_ofs++;
      else if (dn && !up && m_ofs > 0) m_ofs--;
    end
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("hex",     64'(hex),     64'(e.hex));
    check("led",     64'(led),     64'(e.led));
    check("count",   64'(count),   64'(e.cnt));
    check("at_live", 64'(at_live), 64'(e.live));
    check("lost",    64'(lost),    64'(e.lost));
    kbd_if.new_code = 1'b0;
    scroll_up = 1'b0;
    scroll_dn = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic wr(input logic [7:0] c, input bit mb);
    step(1, c, mb, 0, 0, 0, 0);
  endtask

  task automatic up1();
    step(0, 8'h00, 0, 1, 0, 0, 0);
  endtask

  task automatic do_clear();
    step(0, 8'h00, 0, 0, 0, 0, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks   = 0;
    failures = 0;
    m_ofs    = 0;
    m_lost   = 0;
    kbd_if.new_code   = 1'b0;
    kbd_if.code       = '0;
    kbd_if.make_break = 1'b0;

    // Reset state
    #2;
    check("rst_hex",   64'(hex),     64'(ALL_BLANK));
    check("rst_led",   64'(led),     64'(0));
    check("rst_count", 64'(count),   64'(0));
    check("rst_live",  64'(at_live), 64'(1));
    check("rst_lost",  64'(lost),    64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // 1: three writes
    wr(8'h1C, 1); wr(8'hF0, 0); wr(8'h1C, 0);
    check("t1_hex",   64'(hex),      64'(hex3(8'h1C, 8'hF0, 8'h1C)));
    check("t1_count", 64'(count),    64'(3));
    check("t1_led",   64'(led[2:0]), 64'(3'b100));

    // 2: overflow, then scroll to the oldest limit
    do_clear();
    for (int i = 1; i <= 20; i++) wr(8'(i), i[0]);
    check("t2_count", 64'(count), 64'(16));
    check("t2_hex",   64'(hex),   64'(hex3(8'h12, 8'h13, 8'h14)));
    for (int i = 0; i < 14; i++) up1();
    check("t2_hex_top", 64'(hex),     64'(hex3(8'h05, 8'h06, 8'h07)));
    check("t2_live",    64'(at_live), 64'(0));

    // 3: write while scrolled keeps the window; simultaneous scroll holds
    do_clear();
    for (int i = 1; i <= 5; i++) wr(8'(i), 0);
    up1(); up1();
    check("t3_hex_a", 64'(hex), 64'(hex3(8'h01, 8'h02, 8'h03)));
    wr(8'h06, 1);
    check("t3_hex_b", 64'(hex), 64'(hex3(8'h01, 8'h02, 8'h03)));
    step(0, 8'h00, 0, 1, 1, 0, 0);
    check("t3_hex_c", 64'(hex), 64'(hex3(8'h01, 8'h02, 8'h03)));

    // 4: frozen code is dropped and flagged; clear empties everything
    step(1, 8'h2A, 1, 0, 0, 1, 0);
    check("t4_lost",  64'(lost),  64'(1));
    check("t4_count", 64'(count), 64'(6));
    do_clear();
    check("t4_clr_hex",  64'(hex),  64'(ALL_BLANK));
    check("t4_clr_lost", 64'(lost), 64'(0));

    // 5: clear beats a same-cycle write
    step(1, 8'h33, 1, 0, 0, 0, 1);
    check("t5_count", 64'(count), 64'(0));
    wr(8'hA5, 1); wr(8'h5A, 0);
    check("t5_hex", 64'(hex), 64'({7'h7F, 7'h7F, seg7(4'hA), seg7(4'h5), seg7(4'h5), seg7(4'hA)}));

    // Mixed traffic including freeze, scrolling at both limits and wrap
    for (int n = 0; n < 250; n++) begin
      int r = int'($urandom_range(0, 15));
      step(r < 8, 8'($urandom), 1'($urandom), (r >= 8 && r < 12) || r == 15,
           (r >= 12) || r == 1, $urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0);
    end

    // 6: asynchronous reset between edges
    do_clear();
    for (int i = 1; i <= 7; i++) wr(8'(8'h40 + i), 1);
    up1(); up1();
    check("t6_pre_live", 64'(at_live), 64'(0));
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_hex",   64'(hex),     64'(ALL_BLANK));
    check("t6_count", 64'(count),   64'(0));
    check("t6_live",  64'(at_live), 64'(1));
    check("t6_led",   64'(led),     64'(0));
    hist.delete();
    m_ofs  = 0;
    m_lost = 0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(8'h77, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
